ofs_plat_axi_stream_width_packer: RTL and testbench

//  Upstream feeder for an ofs_plat_axi_stream_if sink. Packs RATIO consecutive narrow
//   AXI-S beats into one wide beat.
//  A narrow tlast closes the wide beat early; m_tkeep marks the lanes that were filled.

---
 rtl/ofs_plat_axi_stream_width_packer_if.sv | 17 +
 rtl/ofs_plat_axi_stream_width_packer.sv | 131 +++++++++++++
 tb/tb_ofs_plat_axi_stream_width_packer.sv | 250 +++++++++++++++++++++++++
 3 files changed

// File: rtl/ofs_plat_axi_stream_width_packer_if.sv
// AXI-S style stream bundle used on both sides of the width packer.
// The producer takes the master modport; the consumer takes the slave modport.
interface ofs_plat_axi_stream_width_packer_if #(
  parameter int DATA_W = 64,
  parameter int USER_W = 8,
  parameter int KEEP_W = 1
);
  logic              tvalid;
  logic              tready;
  logic [DATA_W-1:0] tdata;
  logic [USER_W-1:0] tuser;
  logic              tlast;
  logic [KEEP_W-1:0] tkeep;

  modport master (output tvalid, tdata, tuser, tlast, tkeep, input tready);
  modport slave  (input tvalid, tdata, tuser, tlast, tkeep, output tready);
endinterface

// File: rtl/ofs_plat_axi_stream_width_packer.sv
// Packs RATIO narrow AXI-S beats into one registered wide beat. A narrow
// tlast closes the wide beat early; tkeep marks the filled lanes.

// One accumulator lane: holds its narrow beat until the wide beat closes,
// and presents the merged (incoming-or-held) value for the closing edge.
module ofs_plat_axi_stream_width_packer_lane #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         wr,
  input  logic         clr,
  input  logic [W-1:0] din,
  output logic [W-1:0] mrg_data,
  output logic         mrg_keep
);
  logic [W-1:0] acc;
  logic         keep;

  // Capture on write; a completion empties the lane for the next wide beat
  always_ff @(posedge clk) begin
    if (reset || clr) begin
      acc  <= '0;
      keep <= 1'b0;
    end else if (wr) begin
      acc  <= din;
      keep <= 1'b1;
    end
  end

  assign mrg_data = wr ? din : acc;
  assign mrg_keep = wr | keep;
endmodule

module ofs_plat_axi_stream_width_packer #(
  parameter int IN_WIDTH   = 64,
  parameter int RATIO      = 4,
  parameter int USER_WIDTH = 8
) (
  input logic clk,
  input logic reset,
  ofs_plat_axi_stream_width_packer_if.slave  s,
  ofs_plat_axi_stream_width_packer_if.master m
);
  localparam int LW = $clog2(RATIO);
  localparam int PW = RATIO*IN_WIDTH + USER_WIDTH + 1 + RATIO;

  logic [LW-1:0]                    lane;
  logic [USER_WIDTH-1:0]            user_acc, user_cur, user_q;
  logic                             accept, done;
  logic [RATIO-1:0][IN_WIDTH-1:0]   mrg_data, data_q;
  logic [RATIO-1:0]                 mrg_keep, keep_q;
  logic                             vld_q, last_q;
  logic                             unused;

  // Upstream stalls whenever a wide beat is held, even if it would not complete
  assign s.tready = !vld_q || m.tready;
  assign accept   = s.tvalid && s.tready;
  assign done     = accept && (s.tlast || lane == LW'(RATIO-1));
  assign user_cur = (lane == '0) ? s.tuser : user_acc;
  assign unused   = ^s.tkeep;

  for (genvar i = 0; i < RATIO; i++) begin : g_lane
    ofs_plat_axi_stream_width_packer_lane #(.W(IN_WIDTH)) u_lane (
      .clk      (clk),
      .reset    (reset),
      .wr       (accept && lane == LW'(i)),
      .clr      (done),
      .din      (s.tdata),
      .mrg_data (mrg_data[i]),
      .mrg_keep (mrg_keep[i])
    );
  end

  // Lane pointer: advance per accept, restart at lane 0 after each wide beat
  always_ff @(posedge clk) begin
    if (reset)       lane <= '0;
    else if (done)   lane <= '0;
    else if (accept) lane <= lane + LW'(1);
  end

  // tuser of the first narrow beat represents the whole wide beat
  always_ff @(posedge clk) begin
    if (reset)                      user_acc <= '0;
    else if (accept && lane == '0)  user_acc <= s.tuser;
  end

  // Output register: load on completion, drop valid on a drain with no reload
  always_ff @(posedge clk) begin
    if (reset) begin
      vld_q  <= 1'b0;
      data_q <= '0;
      keep_q <= '0;
      user_q <= '0;
      last_q <= 1'b0;
    end else if (done) begin
      vld_q  <= 1'b1;
      data_q <= mrg_data;
      keep_q <= mrg_keep;
      user_q <= user_cur;
      last_q <= s.tlast;
    end else if (vld_q && m.tready) begin
      vld_q  <= 1'b0;
    end
  end

  assign m.tvalid = vld_q;
  assign m.tdata  = data_q;
  assign m.tkeep  = keep_q;
  assign m.tuser  = user_q;
  assign m.tlast  = last_q;

`ifndef SYNTHESIS
  logic          hold_q;
  logic [PW-1:0] pay_q;

  // Protocol watch: no X handshakes, and a held wide beat never changes or vanishes
  always_ff @(posedge clk) begin
    if (!reset) begin
      if ($isunknown(s.tvalid) || $isunknown(m.tready))
        $fatal(1, "packer: X on s_tvalid or m_tready");
      if (hold_q && !vld_q)
        $fatal(1, "packer: m_tvalid dropped without handshake");
      if (hold_q && {data_q, user_q, last_q, keep_q} != pay_q)
        $fatal(1, "packer: payload changed without handshake");
    end
    hold_q <= !reset && vld_q && !m.tready;
    pay_q  <= {data_q, user_q, last_q, keep_q};
  end
`endif
endmodule

// File: tb/tb_ofs_plat_axi_stream_width_packer.sv
// Directed + randomized check of the stream width packer (64b x4 -> 256b).
module tb_ofs_plat_axi_stream_width_packer;
  localparam int IW = 64;
  localparam int R  = 4;
  localparam int UW = 8;
  localparam int OW = IW*R;

  typedef struct {
    logic [OW-1:0] data;
    logic [UW-1:0] user;
    logic          last;
    logic [R-1:0]  keep;
  } wbeat_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic rdy_fixed = 1'b1;
  logic rnd_rdy = 1'b0;
  logic rnd_bit = 1'b1;
  int   n_chk = 0;
  int   n_fail = 0;
  int   stall_cyc = 0;
  wbeat_t got_q[$];
  wbeat_t exp_q[$];

  ofs_plat_axi_stream_width_packer_if #(.DATA_W(IW), .USER_W(UW), .KEEP_W(1)) s_if ();
  ofs_plat_axi_stream_width_packer_if #(.DATA_W(OW), .USER_W(UW), .KEEP_W(R)) m_if ();

  ofs_plat_axi_stream_width_packer #(.IN_WIDTH(IW), .RATIO(R), .USER_WIDTH(UW)) dut (
    .clk   (clk),
    .reset (reset),
    .s     (s_if.slave),
    .m     (m_if.master)
  );

  always #5 clk = ~clk;

  assign m_if.tready = rnd_rdy ? rnd_bit : rdy_fixed;

  // Random sink readiness (~75% ready), changed just after each edge
  always @(posedge clk) begin
    #1;
    rnd_bit = ($urandom_range(0, 3) != 0);
  end

  // Collect every wide beat that handshakes on the coming edge
  always @(negedge clk) begin
    if (!reset && m_if.tvalid && m_if.tready)
      got_q.push_back('{m_if.tdata, m_if.tuser, m_if.tlast, m_if.tkeep});
  end

  initial begin
    #5ms;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input logic [UW-1:0] u, input logic l);
    int n = 0;
    s_if.tvalid = 1'b1;
    s_if.tdata  = d;
    s_if.tuser  = u;
    s_if.tlast  = l;
    @(negedge clk);
    while (!s_if.tready && n < 1000) begin
      n++;
      stall_cyc++;
      @(negedge clk);
    end
    if (n >= 1000) chk("send_timeout", 0, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int cyc);
    s_if.tvalid = 1'b0;
    s_if.tlast  = 1'b0;
    repeat (cyc) @(posedge clk);
    #1;
  endtask

  task automatic expect_beat(input string tag, input logic [OW-1:0] d, input logic [UW-1:0] u,
                             input logic l, input logic [R-1:0] k);
    wbeat_t b;
    int n = 0;
    while (got_q.size() == 0 && n < 200) begin
      @(posedge clk);
      n++;
    end
    if (got_q.size() == 0) begin
      chk({tag, "_timeout"}, 0, 1);
      return;
    end
    b = got_q.pop_front();
    chk({tag, "_data"}, b.data, d);
    chk({tag, "_user"}, OW'(b.user), OW'(u));
    chk({tag, "_last"}, OW'(b.last), OW'(l));
    chk({tag, "_keep"}, OW'(b.keep), OW'(k));
  endtask

  initial begin
    logic [OW-1:0] md;
    logic [R-1:0]  mk;
    logic [UW-1:0] mu;
    logic [IW-1:0] d;
    logic [UW-1:0] u;
    logic          l;
    int            mc;
    wbeat_t        g, e;
    int            n;

    s_if.tvalid = 1'b0;
    s_if.tdata  = '0;
    s_if.tuser  = '0;
    s_if.tlast  = 1'b0;
    s_if.tkeep  = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;

    // reset state
    @(negedge clk);
    chk("rst_tvalid", OW'(m_if.tvalid), 0);
    chk("rst_tdata",  m_if.tdata, 0);
    chk("rst_tuser",  OW'(m_if.tuser), 0);
    chk("rst_tlast",  OW'(m_if.tlast), 0);
    chk("rst_tkeep",  OW'(m_if.tkeep), 0);
    chk("rst_tready", OW'(s_if.tready), 1);
    @(posedge clk);
    #1;

    // full packet, users differ per beat
    send(64'h11, 8'd1, 1'b0);
    send(64'h22, 8'd2, 1'b0);
    send(64'h33, 8'd3, 1'b0);
    send(64'h44, 8'd4, 1'b1);
    idle(1);
    expect_beat("full", {64'h44, 64'h33, 64'h22, 64'h11}, 8'd1, 1'b1, 4'b1111);

    // early close by tlast
    send(64'hA, 8'd5, 1'b0);
    send(64'hB, 8'd6, 1'b1);
    idle(1);
    expect_beat("early", {64'h0, 64'h0, 64'hB, 64'hA}, 8'd5, 1'b1, 4'b0011);

    // 8 back-to-back beats, no tlast
    stall_cyc = 0;
    for (int i = 0; i < 8; i++) send(64'h100 + 64'(i), 8'h10 + 8'(i), 1'b0);
    idle(1);
    chk("burst_stall", OW'(stall_cyc), 0);
    expect_beat("burst0", {64'h103, 64'h102, 64'h101, 64'h100}, 8'h10, 1'b0, 4'b1111);
    expect_beat("burst1", {64'h107, 64'h106, 64'h105, 64'h104}, 8'h14, 1'b0, 4'b1111);

    // back-pressure: beat held, upstream stalled, payload frozen
    rdy_fixed = 1'b0;
    for (int i = 0; i < 4; i++) send(64'h201 + 64'(i), 8'h21 + 8'(i), 1'b0);
    s_if.tvalid = 1'b1;
    s_if.tdata  = 64'h205;
    s_if.tuser  = 8'h25;
    s_if.tlast  = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("bp_tready", OW'(s_if.tready), 0);
      chk("bp_tvalid", OW'(m_if.tvalid), 1);
      chk("bp_tdata",  m_if.tdata, {64'h204, 64'h203, 64'h202, 64'h201});
      chk("bp_tkeep",  OW'(m_if.tkeep), 4'hF);
    end
    @(posedge clk);
    #1;
    rdy_fixed = 1'b1;
    send(64'h205, 8'h25, 1'b0);
    send(64'h206, 8'h26, 1'b0);
    send(64'h207, 8'h27, 1'b0);
    send(64'h208, 8'h28, 1'b1);
    idle(1);
    expect_beat("bp0", {64'h204, 64'h203, 64'h202, 64'h201}, 8'h21, 1'b0, 4'b1111);
    expect_beat("bp1", {64'h208, 64'h207, 64'h206, 64'h205}, 8'h25, 1'b1, 4'b1111);

    // reset discards a partial wide beat
    send(64'h301, 8'h31, 1'b0);
    send(64'h302, 8'h32, 1'b0);
    idle(0);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("mrst_tvalid", OW'(m_if.tvalid), 0);
    chk("mrst_tdata",  m_if.tdata, 0);
    @(posedge clk);
    #1;
    send(64'h401, 8'h41, 1'b0);
    send(64'h402, 8'h42, 1'b0);
    send(64'h403, 8'h43, 1'b0);
    send(64'h404, 8'h44, 1'b1);
    idle(1);
    expect_beat("mrst", {64'h404, 64'h403, 64'h402, 64'h401}, 8'h41, 1'b1, 4'b1111);
    chk("pre_rand_empty", OW'(got_q.size()), 0);

    // random valid/ready against a packet-level reference
    rnd_rdy = 1'b1;
    md = '0; mk = '0; mu = '0; mc = 0;
    for (int b = 0; b < 2000; b++) begin
      d = {$urandom, $urandom};
      u = UW'($urandom);
      l = ($urandom_range(0, 4) == 0) || (b == 1999);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
      send(d, u, l);
      if (mc == 0) mu = u;
      md[mc*IW +: IW] = d;
      mk[mc] = 1'b1;
      if (l || mc == R-1) begin
        exp_q.push_back('{md, mu, l, mk});
        md = '0; mk = '0; mc = 0;
      end else begin
        mc++;
      end
    end
    idle(1);
    n = 0;
    while (got_q.size() < exp_q.size() && n < 2000) begin
      @(posedge clk);
      n++;
    end
    #1;
    rnd_rdy = 1'b0;
    chk("rand_count", OW'(got_q.size()), OW'(exp_q.size()));
    while (got_q.size() > 0 && exp_q.size() > 0) begin
      g = got_q.pop_front();
      e = exp_q.pop_front();
      chk("rand_data", g.data, e.data);
      chk("rand_user", OW'(g.user), OW'(e.user));
      chk("rand_last", OW'(g.last), OW'(e.last));
      chk("rand_keep", OW'(g.keep), OW'(e.keep));
    end
    repeat (4) @(posedge clk);
    chk("tail_empty", OW'(got_q.size()), 0);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
